mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- N-channel arbiter for one single-port data RAM. Requesters are the processor, UART TX fetch, UART RX store and any later DMA-style engines.
- Replaces the fixed tx_en/rx_en steering with a parametrised request/grant handshake, fixed-priority or round-robin selection, locked bursts with a starvation bound, and read-data return routed by channel.
- Sits between the requesters and the RAM address/data/write-enable pins.

Parameters:
- ADDR_W, 15, address width.
- DATA_W, 8, data width.
- N_CH, 3, number of requesters; channel 0 is the processor.
- RD_LAT, 1, RAM read latency in cycles from the registered mem_addr; range 1..4.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_BURST, 16, maximum consecutive locked grants to one channel; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CH  access request per channel.
- lock  in  N_CH  request to keep the grant for the following access.
- we  in  N_CH  1 = write, 0 = read.
- addr  in  N_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_CH*DATA_W  per-channel write data, packed the same way.
- gnt  out  N_CH  one-hot, one-cycle pulse: the access was issued this cycle.
- rvalid  out  N_CH  one-hot pulse marking read data for that channel.
- rdata  out  DATA_W  read data, broadcast to all channels; qualified by rvalid.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_wren  out  1  RAM write enable (registered).
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_addr.

Behaviour:
- Reset values:
  - gnt, rvalid, mem_wren = 0; mem_addr, mem_wdata, rdata = 0.
  - Round-robin pointer = 0; burst counter = 0; state = IDLE; read pipeline flushed.
- Requester protocol:
  - req, we, addr and wdata are held stable until gnt is sampled high.
  - The requester may present its next access in the cycle after gnt (back-to-back).
  - Dropping req before gnt is legal and withdraws the request.
- Issue:
  - At most one access per cycle.
  - On the issuing clock edge: gnt[w], mem_addr, mem_wdata and mem_wren = we[w] all register together, so the access is visible one cycle after the winning request is sampled.
  - On cycles with no winner: mem_wren = 0, gnt = 0, and mem_addr/mem_wdata hold their last values.
- Selection in IDLE:
  - ARB_MODE=0: lowest set index in req.
  - ARB_MODE=1: first set index at or above ptr, wrapping modulo N_CH.
  - After each IDLE grant to w: ptr = (w+1) mod N_CH, wrapping N_CH-1 to 0.
- State machine IDLE / BURST:
  - IDLE -> BURST(owner=w): grant to w with lock[w]=1; burst counter = 1.
  - BURST: only the owner is eligible. Each owner grant increments the counter.
  - BURST -> IDLE when any of:
    - lock[owner]=0 at a grant (that grant still issues);
    - req[owner]=0;
    - the counter reaches MAX_BURST. That grant issues, then a forced IDLE lasts at least one arbitration in which the owner gets lowest priority (round-robin ptr = owner+1; in fixed mode the owner is masked for one cycle).
  - The pointer does not advance during a burst; ptr = owner+1 on exit.
- Read return:
  - RD_LAT-deep shift pipeline carries {valid, channel id} for reads only.
  - rvalid[id] and rdata <= mem_rdata are registered together, RD_LAT+1 cycles after the gnt edge.
  - Writes produce no rvalid.
  - Reads are issuable back-to-back; rvalid order equals issue order.
- Simultaneous events:
  - A grant and a returning read in the same cycle are independent.
  - A new request from the channel receiving rvalid is legal.
- Reset mid-operation: the pipeline is flushed, pending reads produce no rvalid, and state returns to IDLE.

Decomposition:
- Package mem_arb_pkg:
  - ARB_FIXED / ARB_RR constants.
  - State enum {IDLE, BURST}.
  - clog2-based channel-id width function.
  - Packed-vector slice helpers.
- Sub-module rr_pick:
  - Combinational; inputs req, mask and ptr; outputs one-hot win plus encoded index.
  - Shared by both modes (fixed mode uses ptr=0).

Test Plan:
- Fixed mode, req=3'b111 held, all reads: gnt sequence ch0 every cycle; ch1 and ch2 get no grant while ch0 requests.
- Round-robin, req=3'b111 held, no lock: gnt order 0,1,2,0,1,2. mem_addr matches addr[ch] one cycle after each request is sampled.
- Read ch2 at addr 0x1234 with RD_LAT=2 and the RAM model returning 0xA5: rvalid=3'b100, rdata=0xA5 exactly 3 cycles after the gnt edge. A write issued by ch1 in the next cycle produces no rvalid.
- ch1 lock=1 with a continuous write burst, MAX_BURST=4, ch0/ch2 requesting: four consecutive gnt[1] with mem_wren=1, then gnt[2], then gnt[0].
- ch0 lock released after 2 grants (lock=0 on 2nd grant): the 2nd access is issued, then normal round-robin resumes from ptr=1.
- Assert rst_n low for one cycle with 2 reads in flight (RD_LAT=2): all outputs 0 immediately, no rvalid afterwards, first grant after release goes to the lowest requesting index.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types, arbitration-mode constants and helper functions
//               for the single-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of an encoded channel index; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of element idx within a packed vector of width-sized fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_port_arb_if.sv
// ============================================================================
// Module      : mem_port_arb_if
// Description : Requester-side bundle: request/lock/access fields in,
//               grant and channel-routed read return out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arb_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int N_CH   = 3
);
    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        lock;
    logic [N_CH-1:0]        we;
    logic [N_CH*ADDR_W-1:0] addr;
    logic [N_CH*DATA_W-1:0] wdata;
    logic [N_CH-1:0]        gnt;
    logic [N_CH-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface : mem_port_arb_if

`default_nettype wire

// File: rtl/mem_port_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational picker: first eligible request at or above ptr,
//               wrapping; one-hot and encoded winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_CH = 3,
    parameter int IDW  = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] mask,
    input  logic [IDW-1:0]  ptr,
    output logic [N_CH-1:0] win,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [N_CH-1:0] w_elig;
    int              w_ch;

    assign w_elig = req & ~mask;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        w_ch  = 0;
        for (int k = 0; k < N_CH; k++) begin
            w_ch = (int'(ptr) + k) % N_CH;
            if (!found && w_elig[w_ch]) begin
                found     = 1'b1;
                win[w_ch] = 1'b1;
                idx       = IDW'(w_ch);
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/mem_port_arb.sv
// ============================================================================
// Module      : mem_port_arb
// Description : N-channel request/grant arbiter for one single-port RAM with
//               locked bursts, starvation bound and routed read return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int N_CH      = 3,
    parameter int RD_LAT    = 1,
    parameter int ARB_MODE  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arb_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_IDW = id_width(N_CH);

    arb_state_t               r_state;
    logic [c_IDW-1:0]         r_owner;
    logic [c_IDW-1:0]         r_ptr;
    logic [7:0]               r_cnt;
    logic [N_CH-1:0]          r_mask;
    logic [N_CH-1:0]          r_gnt;
    logic [c_IDW-1:0]         r_gnt_id;
    logic                     r_rd_issued;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [DATA_W-1:0]        r_mem_wdata;
    logic                     r_mem_wren;
    logic [RD_LAT-1:0]        r_pv;
    logic [RD_LAT-1:0][c_IDW-1:0] r_pid;
    logic [N_CH-1:0]          r_rvalid;
    logic [DATA_W-1:0]        r_rdata;

    logic [N_CH-1:0]          w_owner_oh;
    logic [N_CH-1:0]          w_pick_mask;
    logic [c_IDW-1:0]         w_pick_ptr;
    logic [N_CH-1:0]          w_win;
    logic [c_IDW-1:0]         w_idx;
    logic                     w_any;

    function automatic logic [c_IDW-1:0] f_inc(input logic [c_IDW-1:0] v);
        return (v == c_IDW'(N_CH - 1)) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    // During a burst only the owner is eligible; in fixed mode a forced exit
    // masks the previous owner for exactly one arbitration.
    assign w_pick_mask = (r_state == BURST)       ? ~w_owner_oh :
                         (ARB_MODE == ARB_FIXED)  ? r_mask      : '0;
    assign w_pick_ptr  = (ARB_MODE == ARB_RR) ? r_ptr : '0;

    rr_pick #(
        .N_CH (N_CH),
        .IDW  (c_IDW)
    ) u_pick (
        .req   (bus.req),
        .mask  (w_pick_mask),
        .ptr   (w_pick_ptr),
        .win   (w_win),
        .idx   (w_idx),
        .found (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_rd_issued <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_mem_wren  <= 1'b0;
            r_mask      <= '0;
            r_rd_issued <= 1'b0;
            if (w_any) begin
                r_gnt       <= w_win;
                r_gnt_id    <= w_idx;
                r_mem_addr  <= bus.addr[slice_lo(int'(w_idx), ADDR_W) +: ADDR_W];
                r_mem_wdata <= bus.wdata[slice_lo(int'(w_idx), DATA_W) +: DATA_W];
                r_mem_wren  <= bus.we[w_idx];
                r_rd_issued <= ~bus.we[w_idx];
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr <= f_inc(w_idx);
                        if (bus.lock[w_idx]) begin
                            r_state <= BURST;
                            r_owner <= w_idx;
                            r_cnt   <= 8'd1;
                        end
                    end
                end
                BURST: begin
                    if (!w_any || !bus.lock[r_owner]) begin
                        r_state <= IDLE;
                        r_ptr   <= f_inc(r_owner);
                        r_cnt   <= '0;
                    end else if (r_cnt == 8'(MAX_BURST - 1)) begin
                        r_state <= IDLE;
                        r_ptr   <= f_inc(r_owner);
                        r_cnt   <= '0;
                        if (ARB_MODE == ARB_FIXED) begin
                            r_mask <= w_owner_oh;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read tags are fed from the registered issue, so the return lands
    // RD_LAT+1 edges after the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv     <= '0;
            r_pid    <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_pv[0]  <= r_rd_issued;
            r_pid[0] <= r_gnt_id;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
            end
            r_rvalid <= '0;
            if (r_pv[RD_LAT-1]) begin
                r_rvalid[r_pid[RD_LAT-1]] <= 1'b1;
                r_rdata                   <= mem_rdata;
            end
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wren   = r_mem_wren;

endmodule : mem_port_arb

`default_nettype wire

// File: tb/tb_mem_port_arb.sv
// ============================================================================
// Module      : tb_mem_port_arb
// Description : Scoreboard bench: fixed-priority and round-robin instances
//               driven with directed vectors, checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arb;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int NC = 3;
    localparam int RL = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_fix, rst_n_rr;
    logic [NC-1:0]    req, lock, we;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;

    mem_port_arb_if #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC)) bus_fix ();
    mem_port_arb_if #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC)) bus_rr ();

    assign bus_fix.req = req;  assign bus_fix.lock = lock; assign bus_fix.we = we;
    assign bus_fix.addr = addr; assign bus_fix.wdata = wdata;
    assign bus_rr.req = req;   assign bus_rr.lock = lock;  assign bus_rr.we = we;
    assign bus_rr.addr = addr;  assign bus_rr.wdata = wdata;

    logic [AW-1:0] ma_fix, ma_rr;
    logic [DW-1:0] mwd_fix, mwd_rr, mrd_fix, mrd_rr;
    logic          mwe_fix, mwe_rr;

    mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC), .RD_LAT(RL),
                   .ARB_MODE(0), .MAX_BURST(MB)) dut_fix (
        .clk(clk), .rst_n(rst_n_fix), .bus(bus_fix.slave),
        .mem_addr(ma_fix), .mem_wdata(mwd_fix), .mem_wren(mwe_fix), .mem_rdata(mrd_fix));

    mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC), .RD_LAT(RL),
                   .ARB_MODE(1), .MAX_BURST(MB)) dut_rr (
        .clk(clk), .rst_n(rst_n_rr), .bus(bus_rr.slave),
        .mem_addr(ma_rr), .mem_wdata(mwd_rr), .mem_wren(mwe_rr), .mem_rdata(mrd_rr));

    function automatic logic [7:0] ram_val(input logic [14:0] a);
        return (a == 15'h1234) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    // RAM model: data for mem_addr is presented RL cycles later.
    logic [7:0] p0_fix = '0, p1_fix = '0, p0_rr = '0, p1_rr = '0;
    always_ff @(posedge clk) begin
        p0_fix <= ram_val(ma_fix);
        p1_fix <= p0_fix;
        p0_rr  <= ram_val(ma_rr);
        p1_rr  <= p0_rr;
    end
    assign mrd_fix = p1_fix;
    assign mrd_rr  = p1_rr;

    typedef struct packed {
        logic [1:0]  ch;
        logic [14:0] a;
        logic        wr;
        logic [7:0]  d;
    } gexp_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } rexp_t;

    gexp_t gq_fix[$], gq_rr[$];
    rexp_t rq_fix[$], rq_rr[$];
    int    rdcyc_fix[$], rdcyc_rr[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic [2:0] g, input logic [14:0] ma,
                       input logic [7:0] mwd, input logic mw,
                       input logic [2:0] rv, input logic [7:0] rd);
        gexp_t e;
        rexp_t r;
        int    gc;
        int    qs;
        string tag;
        tag = (d == 0) ? "fix" : "rr";
        if (g != 3'b000) begin
            qs = (d == 0) ? gq_fix.size() : gq_rr.size();
            if (qs == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s unexpected gnt: got %b want none (cycle %0d)", tag, g, cyc);
            end else begin
                if (d == 0) e = gq_fix.pop_front();
                else        e = gq_rr.pop_front();
                check({tag, " gnt"},      32'(g),  32'(3'b001 << e.ch));
                check({tag, " mem_addr"}, 32'(ma), 32'(e.a));
                check({tag, " mem_wren"}, 32'(mw), 32'(e.wr));
                if (e.wr) check({tag, " mem_wdata"}, 32'(mwd), 32'(e.d));
                else if (d == 0) rdcyc_fix.push_back(cyc);
                else             rdcyc_rr.push_back(cyc);
            end
        end else begin
            check({tag, " idle mem_wren"}, 32'(mw), 32'd0);
        end
        if (rv != 3'b000) begin
            qs = (d == 0) ? rq_fix.size() : rq_rr.size();
            if (qs == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s unexpected rvalid: got %b want none (cycle %0d)", tag, rv, cyc);
            end else begin
                if (d == 0) begin
                    r  = rq_fix.pop_front();
                    gc = (rdcyc_fix.size() > 0) ? rdcyc_fix.pop_front() : -100;
                end else begin
                    r  = rq_rr.pop_front();
                    gc = (rdcyc_rr.size() > 0) ? rdcyc_rr.pop_front() : -100;
                end
                check({tag, " rvalid"},  32'(rv), 32'(3'b001 << r.ch));
                check({tag, " rdata"},   32'(rd), 32'(r.d));
                check({tag, " rd_lat"},  32'(cyc - gc), 32'(RL + 1));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_fix.gnt, ma_fix, mwd_fix, mwe_fix, bus_fix.rvalid, bus_fix.rdata);
        mon(1, bus_rr.gnt,  ma_rr,  mwd_rr,  mwe_rr,  bus_rr.rvalid,  bus_rr.rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int c, input logic r, input logic l, input logic w,
                         input logic [14:0] a, input logic [7:0] dd);
        req[c]            = r;
        lock[c]           = l;
        we[c]             = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = dd;
    endtask

    task automatic pg(input int d, input int ch, input logic [14:0] a,
                      input logic wr, input logic [7:0] dd);
        gexp_t e;
        e = '{ch: 2'(ch), a: a, wr: wr, d: dd};
        if (d == 0) gq_fix.push_back(e);
        else        gq_rr.push_back(e);
    endtask

    task automatic pr(input int d, input int ch, input logic [7:0] dd);
        rexp_t r;
        r = '{ch: 2'(ch), d: dd};
        if (d == 0) rq_fix.push_back(r);
        else        rq_rr.push_back(r);
    endtask

    task automatic chk_zero(input string tag, input logic [2:0] g, input logic [2:0] rv,
                            input logic [14:0] ma, input logic [7:0] mwd,
                            input logic [7:0] rd, input logic mw);
        check({tag, " gnt"},       32'(g),   32'd0);
        check({tag, " rvalid"},    32'(rv),  32'd0);
        check({tag, " mem_addr"},  32'(ma),  32'd0);
        check({tag, " mem_wdata"}, 32'(mwd), 32'd0);
        check({tag, " rdata"},     32'(rd),  32'd0);
        check({tag, " mem_wren"},  32'(mw),  32'd0);
    endtask

    initial begin
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        rst_n_fix = 1'b0;
        rst_n_rr  = 1'b0;
        repeat (2) step();
        rst_n_fix = 1'b1;
        step();
        chk_zero("fix reset", bus_fix.gnt, bus_fix.rvalid, ma_fix, mwd_fix, bus_fix.rdata, mwe_fix);

        // Fixed priority, all three reading: ch0 wins every cycle.
        setch(0, 1, 0, 0, 15'h0010, 8'h00);
        setch(1, 1, 0, 0, 15'h0020, 8'h00);
        setch(2, 1, 0, 0, 15'h0030, 8'h00);
        for (int i = 0; i < 4; i++) begin
            pg(0, 0, 15'h0010, 1'b0, 8'h00);
            pr(0, 0, 8'h2C);
        end
        repeat (4) step();
        req = '0;
        repeat (6) step();
        rst_n_fix = 1'b0;

        rst_n_rr = 1'b1;
        step();
        chk_zero("rr reset", bus_rr.gnt, bus_rr.rvalid, ma_rr, mwd_rr, bus_rr.rdata, mwe_rr);

        // Round-robin, all writing, no lock: 0,1,2,0,1,2.
        setch(0, 1, 0, 1, 15'h0100, 8'h11);
        setch(1, 1, 0, 1, 15'h0201, 8'h22);
        setch(2, 1, 0, 1, 15'h0302, 8'h33);
        for (int i = 0; i < 2; i++) begin
            pg(1, 0, 15'h0100, 1'b1, 8'h11);
            pg(1, 1, 15'h0201, 1'b1, 8'h22);
            pg(1, 2, 15'h0302, 1'b1, 8'h33);
        end
        repeat (6) step();
        req = '0;
        step();

        // ch2 read at 0x1234, then ch1 write that returns nothing.
        setch(2, 1, 0, 0, 15'h1234, 8'h00);
        pg(1, 2, 15'h1234, 1'b0, 8'h00);
        pr(1, 2, 8'hA5);
        step();
        req[2] = 1'b0;
        setch(1, 1, 0, 1, 15'h0055, 8'h5A);
        pg(1, 1, 15'h0055, 1'b1, 8'h5A);
        step();
        req = '0;
        repeat (5) step();

        // ch1 locked write burst capped at MB, then ch2, then ch0.
        setch(1, 1, 1, 1, 15'h0400, 8'hB0);
        pg(1, 1, 15'h0400, 1'b1, 8'hB0);
        step();
        setch(1, 1, 1, 1, 15'h0401, 8'hB1);
        setch(0, 1, 0, 1, 15'h0700, 8'hC0);
        setch(2, 1, 0, 1, 15'h0702, 8'hC2);
        pg(1, 1, 15'h0401, 1'b1, 8'hB1);
        step();
        setch(1, 1, 1, 1, 15'h0402, 8'hB2);
        pg(1, 1, 15'h0402, 1'b1, 8'hB2);
        step();
        setch(1, 1, 1, 1, 15'h0403, 8'hB3);
        pg(1, 1, 15'h0403, 1'b1, 8'hB3);
        step();
        req[1] = 1'b0;
        lock[1] = 1'b0;
        pg(1, 2, 15'h0702, 1'b1, 8'hC2);
        step();
        req[2] = 1'b0;
        pg(1, 0, 15'h0700, 1'b1, 8'hC0);
        step();
        req = '0;
        step();

        // ch0 lock released on its second grant; round-robin resumes at 1.
        setch(0, 1, 1, 1, 15'h0500, 8'hD0);
        pg(1, 0, 15'h0500, 1'b1, 8'hD0);
        step();
        setch(0, 1, 0, 1, 15'h0501, 8'hD1);
        setch(1, 1, 0, 1, 15'h0511, 8'hE1);
        setch(2, 1, 0, 1, 15'h0522, 8'hE2);
        pg(1, 0, 15'h0501, 1'b1, 8'hD1);
        step();
        setch(0, 1, 0, 1, 15'h0502, 8'hD2);
        pg(1, 1, 15'h0511, 1'b1, 8'hE1);
        step();
        req[1] = 1'b0;
        pg(1, 2, 15'h0522, 1'b1, 8'hE2);
        step();
        req[2] = 1'b0;
        pg(1, 0, 15'h0502, 1'b1, 8'hD2);
        step();
        req = '0;
        step();

        // Two reads in flight, then a one-cycle reset: they must vanish.
        setch(0, 1, 0, 0, 15'h0600, 8'h00);
        pg(1, 0, 15'h0600, 1'b0, 8'h00);
        step();
        addr[0 +: AW] = 15'h0601;
        pg(1, 0, 15'h0601, 1'b0, 8'h00);
        step();
        req = '0;
        @(negedge clk);
        #1;
        rst_n_rr = 1'b0;
        #1;
        chk_zero("rr async reset", bus_rr.gnt, bus_rr.rvalid, ma_rr, mwd_rr, bus_rr.rdata, mwe_rr);
        step();
        rdcyc_rr.delete();
        rst_n_rr = 1'b1;
        setch(0, 1, 0, 1, 15'h0033, 8'h44);
        setch(2, 1, 0, 1, 15'h0044, 8'h55);
        pg(1, 0, 15'h0033, 1'b1, 8'h44);
        step();
        req[0] = 1'b0;
        pg(1, 2, 15'h0044, 1'b1, 8'h55);
        step();
        req = '0;
        repeat (8) step();

        for (int i = 0; i < 20 && (gq_fix.size() + gq_rr.size() + rq_fix.size() + rq_rr.size()) > 0; i++)
            step();
        check("leftover expected", 32'(gq_fix.size() + gq_rr.size() + rq_fix.size() + rq_rr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_port_arb

`default_nettype wire
